aib_link_seq: RTL and testbench

AIB_LINK_SEQ -- requirements
Module: aib_link_seq

---
 rtl/aib_pkg.sv | 19 +
 rtl/aib_link_seq_if.sv | 23 ++
 rtl/aib_tmo_cnt.sv | 19 +
 rtl/aib_link_seq.sv | 104 ++++++++++
 tb/tb_aib_link_seq.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/aib_pkg.sv
// aib_pkg: shared state encoding and parameter defaults for the AIB link sequencer.
package aib_pkg;
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SETTLE      = 3'd1,
        ST_CAL         = 3'd2,
        ST_WAIT_REMOTE = 3'd3,
        ST_UP          = 3'd4,
        ST_FAIL        = 3'd5
    } aib_link_state_e;

    localparam int SETTLE_CYCLES_DEF  = 16;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int MAX_RETRY_DEF      = 3;

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/aib_link_seq_if.sv
// aib_link_seq_if: control inputs and status outputs of the link sequencer.
interface aib_link_seq_if #(parameter int MAX_RETRY = aib_pkg::MAX_RETRY_DEF);
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic          i_start;
    logic          i_stop;
    logic          i_cal_done;
    logic          i_remote_ready;
    logic          o_cal_req;
    logic          o_config_done;
    logic          o_link_up;
    logic          o_err;
    logic [2:0]    o_state;
    logic [RW-1:0] o_retry_cnt;

    modport master (
        output i_start, i_stop, i_cal_done, i_remote_ready,
        input  o_cal_req, o_config_done, o_link_up, o_err, o_state, o_retry_cnt
    );
    modport slave (
        input  i_start, i_stop, i_cal_done, i_remote_ready,
        output o_cal_req, o_config_done, o_link_up, o_err, o_state, o_retry_cnt
    );
endinterface

// File: rtl/aib_tmo_cnt.sv
// aib_tmo_cnt: phase cycle counter; o_tc flags the cycle whose index equals i_last.
module aib_tmo_cnt #(parameter int W = 4) (
    input  logic         i_aux_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = i_clr ? '0 : i_en ? cnt_q + W'(1) : cnt_q;

    assign o_tc = cnt_q == i_last;

    always_ff @(posedge i_aux_clk or negedge i_rst_n)
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
endmodule

// File: rtl/aib_link_seq.sv
// aib_link_seq: AIB link bring-up sequencer (settle, calibrate, wait for far side, up)
// with per-phase timeouts, bounded retries and a sticky failure state.
module aib_link_seq
    import aib_pkg::*;
#(
    parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int MAX_RETRY      = MAX_RETRY_DEF
) (
    input  logic           i_aux_clk,
    input  logic           i_rst_n,
    aib_link_seq_if.slave  bus
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int CW = $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES));
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    aib_link_state_e state_q, state_d, to_state;
    logic [RW-1:0]   retry_q, retry_d, to_retry;
    logic            cal_req_q, cal_req_d, config_done_q, config_done_d;
    logic            link_up_q, link_up_d, err_q, err_d;
    logic [CW-1:0]   last;
    logic            tc, clr, en;

    assign last = state_q == ST_SETTLE ? CW'(SETTLE_CYCLES - 1) : CW'(TIMEOUT_CYCLES - 1);
    assign clr  = bus.i_stop | (state_d != state_q);
    assign en   = state_q inside {ST_SETTLE, ST_CAL, ST_WAIT_REMOTE};

    aib_tmo_cnt #(.W(CW)) u_tmo (
        .i_aux_clk (i_aux_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (clr),
        .i_en      (en),
        .i_last    (last),
        .o_tc      (tc)
    );

    // A timeout and a link drop from UP share the same saturating retry step.
    assign to_state = retry_q == RMAX ? ST_FAIL : ST_SETTLE;
    assign to_retry = retry_q == RMAX ? retry_q : retry_q + RW'(1);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (bus.i_stop) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.i_start) begin
                    state_d = ST_SETTLE;
                    retry_d = '0;
                end
                ST_SETTLE: if (tc) state_d = ST_CAL;
                ST_CAL: if (bus.i_cal_done) state_d = ST_WAIT_REMOTE;
                    else if (tc) begin
                        state_d = to_state;
                        retry_d = to_retry;
                    end
                ST_WAIT_REMOTE: if (bus.i_remote_ready) begin
                        state_d = ST_UP;
                        retry_d = '0;
                    end else if (tc) begin
                        state_d = to_state;
                        retry_d = to_retry;
                    end
                ST_UP: if (!bus.i_remote_ready) begin
                    state_d = ST_SETTLE;
                    retry_d = to_retry;
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_IDLE;
            endcase
        end
        cal_req_d     = state_d == ST_CAL;
        config_done_d = state_d inside {ST_WAIT_REMOTE, ST_UP};
        link_up_d     = state_d == ST_UP;
        err_d         = state_d == ST_FAIL;
    end

    always_ff @(posedge i_aux_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            retry_q       <= '0;
            cal_req_q     <= 1'b0;
            config_done_q <= 1'b0;
            link_up_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            retry_q       <= retry_d;
            cal_req_q     <= cal_req_d;
            config_done_q <= config_done_d;
            link_up_q     <= link_up_d;
            err_q         <= err_d;
        end

    assign bus.o_cal_req     = cal_req_q;
    assign bus.o_config_done = config_done_q;
    assign bus.o_link_up     = link_up_q;
    assign bus.o_err         = err_q;
    assign bus.o_state       = state_q;
    assign bus.o_retry_cnt   = retry_q;
endmodule

// File: tb/tb_aib_link_seq.sv
// tb_aib_link_seq: directed and random stimulus against a behavioural model;
// expected outputs are queued per cycle and compared by an independent monitor.
module tb_aib_link_seq;
    import aib_pkg::*;
    localparam int S = 4, T = 8, MR = 2;
    localparam int IDLE = 0, SETTLE = 1, CAL = 2, WAITR = 3, UP = 4, FAILST = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aib_link_seq_if #(.MAX_RETRY(MR)) bus();
    aib_link_seq #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
        .i_aux_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    int checks = 0, errors = 0;
    int m_st = IDLE, m_cnt = 0, m_rt = 0;
    bit m_ill = 1'b0;
    logic [8:0] exp_q[$];

    function automatic logic [8:0] model_out();
        logic [2:0] st;
        logic [1:0] rt;
        st = 3'(m_st);
        rt = 2'(m_rt);
        return {m_st == UP, m_st == WAITR || m_st == UP, m_st == CAL, m_st == FAILST, st, rt};
    endfunction

    task automatic model_step(input bit s, input bit st, input bit cd, input bit rr);
        int nx, nr;
        bit timeout;
        if (!rst_n) begin
            m_st = IDLE; m_cnt = 0; m_rt = 0; m_ill = 1'b0;
            return;
        end
        nx = m_st;
        nr = m_rt;
        timeout = m_cnt == T - 1;
        if (m_ill) nx = IDLE;
        else if (st) begin nx = IDLE; nr = 0; end
        else if (m_st == IDLE && s) begin nx = SETTLE; nr = 0; end
        else if (m_st == SETTLE && m_cnt == S - 1) nx = CAL;
        else if (m_st == CAL && cd) nx = WAITR;
        else if (m_st == WAITR && rr) begin nx = UP; nr = 0; end
        else if ((m_st == CAL || m_st == WAITR) && timeout) begin
            nx = m_rt == MR ? FAILST : SETTLE;
            nr = m_rt == MR ? m_rt : m_rt + 1;
        end else if (m_st == UP && !rr) begin
            nx = SETTLE;
            nr = m_rt < MR ? m_rt + 1 : MR;
        end
        m_cnt = (nx != m_st || st) ? 0 : m_cnt + 1;
        m_st = nx;
        m_rt = nr;
        m_ill = 1'b0;
    endtask

    task automatic cyc(input bit s, input bit st, input bit cd, input bit rr);
        bus.i_start = s;
        bus.i_stop = st;
        bus.i_cal_done = cd;
        bus.i_remote_ready = rr;
        model_step(s, st, cd, rr);
        exp_q.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until(input int tgt, input bit s, input bit cd, input bit rr, input int bound);
        for (int i = 0; i < bound && m_st != tgt; i++) cyc(s, 1'b0, cd, rr);
        checks++;
        if (m_st != tgt) begin
            errors++;
            $display("FAIL run_until: reached state %0d, required %0d within %0d cycles", m_st, tgt, bound);
        end
    endtask

    initial begin
        logic [8:0] e, got;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {bus.o_link_up, bus.o_config_done, bus.o_cal_req, bus.o_err, bus.o_state, bus.o_retry_cnt};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got link=%b cfg=%b cal=%b err=%b st=%0d rt=%0d, required link=%b cfg=%b cal=%b err=%b st=%0d rt=%0d",
                             $time, got[8], got[7], got[6], got[5], got[4:2], got[1:0],
                             e[8], e[7], e[6], e[5], e[4:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_cal_done = 1'b0; bus.i_remote_ready = 1'b0;
        @(negedge clk);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // happy path: cal_done on 3rd CAL cycle, remote_ready on 2nd WAIT_REMOTE cycle
        run_until(CAL, 1, 0, 0, 20);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        // link drop from UP, then re-bring-up
        cyc(0, 0, 0, 0);
        run_until(CAL, 0, 0, 0, 20);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        // illegal state code recovers to IDLE
        force dut.state_q = aib_link_state_e'(3'd6);
        #1 release dut.state_q;
        m_ill = 1'b1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        // calibration never completes: retries exhaust into FAIL
        run_until(FAILST, 1, 0, 0, 200);
        cyc(1, 0, 1, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // cal_done exactly on the timeout cycle
        run_until(CAL, 1, 0, 0, 20);
        for (int i = 0; i < T - 1; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        // asynchronous reset mid WAIT_REMOTE
        model_step(1, 0, 0, 0);
        rst_n = 1'b0;
        model_step(1, 0, 0, 0);
        exp_q.push_back(model_out());
        #3;
        cyc(1, 0, 0, 0);
        rst_n = 1'b1;
        cyc(1, 0, 0, 0);
        run_until(CAL, 1, 0, 0, 20);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 1);
        // stop beats cal_done in CAL
        cyc(1, 0, 0, 0);
        run_until(CAL, 1, 0, 0, 20);
        cyc(1, 1, 1, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
